// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Build option: PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte and a CHK state.
package prog_loader_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_W     = 8;
    localparam int BYTE_IDX_W = 2;
    localparam int LEN_W      = 16;

    typedef enum logic [2:0] {
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHK,
        ST_RUN,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader takes the master view; the receiver/memory side takes the slave view.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/prog_loader_byte_assembler.sv
// Packs little-endian bytes into 32-bit words; word_done pulses for one cycle
// after the 4th byte, while the completed word is held on the word output.
module byte_assembler
    import prog_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  global_reset,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [BYTE_W-1:0]     byte_data,
    output logic [WORD_W-1:0]     word,
    output logic                  word_done,
    output logic [BYTE_IDX_W-1:0] byte_idx
);
    localparam int LANES = WORD_W / BYTE_W;

    logic [BYTE_IDX_W-1:0] idx_reg;
    logic                  done_reg;

    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            idx_reg  <= '0;
            done_reg <= 1'b0;
        end else if (clear) begin
            idx_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= byte_valid && (idx_reg == '1);
            if (byte_valid) begin
                idx_reg <= idx_reg + BYTE_IDX_W'(1);
            end
        end
    end

    // One register per byte lane; lane k captures the byte arriving at index k.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [BYTE_W-1:0] lane_reg;

            always_ff @(posedge clk or posedge global_reset) begin
                if (global_reset) begin
                    lane_reg <= '0;
                end else if (clear) begin
                    lane_reg <= '0;
                end else if (byte_valid && (idx_reg == BYTE_IDX_W'(gi))) begin
                    lane_reg <= byte_data;
                end
            end

            assign word[gi*BYTE_W +: BYTE_W] = lane_reg;
        end
    endgenerate

    assign word_done = done_reg;
    assign byte_idx  = idx_reg;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: length header, N little-endian words to imem 0..N-1, then core release.
// Build option: PROG_LOADER_CHECKSUM_EN appends a mod-256 data checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int IMEM_DEPTH = 256
)(
    input  logic          clk,
    input  logic          global_reset,
    input  logic          load_req,
    prog_loader_if.master bus,
    output logic          core_reset,
    output logic          load_done,
    output logic          load_error
);
    localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(IMEM_DEPTH);

    localparam state_t AFTER_DATA =
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHK;
`else
        ST_RUN;
`endif

    state_t                state_reg, state_next;
    logic [BYTE_W-1:0]     len_lo_reg;
    logic [LEN_W-1:0]      len_reg;
    logic [LEN_W-1:0]      cnt_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic                  core_reset_reg;
    logic                  load_done_reg;
    logic                  load_error_reg;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]     sum_reg;
`endif

    logic [LEN_W-1:0]      len_in;
    logic                  restart;
    logic                  asm_clear;
    logic                  asm_strobe;
    logic                  last_byte;
    logic [WORD_W-1:0]     asm_word;
    logic                  asm_done;
    logic [BYTE_IDX_W-1:0] asm_idx;

    assign len_in    = {bus.rx_data, len_lo_reg};
    assign restart   = load_req && ((state_reg == ST_RUN) || (state_reg == ST_ERROR));
    assign last_byte = (asm_idx == '1) && (cnt_reg == len_reg - LEN_W'(1));

    always_comb begin
        state_next = state_reg;
        asm_clear  = restart;
        asm_strobe = 1'b0;
        unique case (state_reg)
            ST_LEN_LO: begin
                if (bus.rx_valid) state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (bus.rx_valid) begin
                    if (len_in > MAX_WORDS) begin
                        state_next = ST_ERROR;
                    end else if (len_in == '0) begin
                        state_next = AFTER_DATA;
                    end else begin
                        state_next = ST_DATA;
                        asm_clear  = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (bus.rx_valid) begin
                    asm_strobe = 1'b1;
                    if (last_byte) state_next = AFTER_DATA;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (bus.rx_valid) begin
                    state_next = (bus.rx_data == sum_reg) ? ST_RUN : ST_ERROR;
                end
            end
`endif
            // Bytes arriving here are dropped; only load_req leaves these states.
            ST_RUN, ST_ERROR: begin
                if (load_req) state_next = ST_LEN_LO;
            end
            default: state_next = ST_LEN_LO;
        endcase
    end

    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            state_reg      <= ST_LEN_LO;
            len_lo_reg     <= '0;
            len_reg        <= '0;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            core_reset_reg <= 1'b1;
            load_done_reg  <= 1'b0;
            load_error_reg <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_reg        <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            // Status flags decode the next state so they track the state register exactly.
            core_reset_reg <= (state_next != ST_RUN);
            load_done_reg  <= (state_next == ST_RUN);
            load_error_reg <= (state_next == ST_ERROR);

            if ((state_reg == ST_LEN_LO) && bus.rx_valid) len_lo_reg <= bus.rx_data;
            if ((state_reg == ST_LEN_HI) && bus.rx_valid) len_reg    <= len_in;

            if (asm_clear) begin
                cnt_reg  <= '0;
                addr_reg <= '0;
            end else if (asm_strobe && (asm_idx == '1)) begin
                // Address of the word being completed is held through its write pulse.
                addr_reg <= cnt_reg[ADDR_W-1:0];
                cnt_reg  <= cnt_reg + LEN_W'(1);
            end

`ifdef PROG_LOADER_CHECKSUM_EN
            if (restart) begin
                sum_reg <= '0;
            end else if (asm_strobe) begin
                sum_reg <= sum_reg + bus.rx_data;
            end
`endif
        end
    end

    byte_assembler u_asm (
        .clk          (clk),
        .global_reset (global_reset),
        .clear        (asm_clear),
        .byte_valid   (asm_strobe),
        .byte_data    (bus.rx_data),
        .word         (asm_word),
        .word_done    (asm_done),
        .byte_idx     (asm_idx)
    );

    assign bus.imem_we    = asm_done;
    assign bus.imem_addr  = addr_reg;
    assign bus.imem_wdata = asm_word;
    assign core_reset     = core_reset_reg;
    assign load_done      = load_done_reg;
    assign load_error     = load_error_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of load streams plus hand-written corner sequences.
// Expected memory writes go to a scoreboard queue and are matched against imem_we pulses.
module tb_prog_loader;

    localparam bit CHK_ON =
`ifdef PROG_LOADER_CHECKSUM_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0]      len;
        logic [2:0][31:0] w;
        bit               gen;
        bit               bad_chk;
        bit               exp_error;
    } vec_t;

    logic clk;
    logic global_reset;
    logic load_req;
    logic core_reset;
    logic load_done;
    logic load_error;

    prog_loader_if #(.ADDR_W(8)) bus ();

    prog_loader #(.ADDR_W(8), .IMEM_DEPTH(256)) dut (
        .clk          (clk),
        .global_reset (global_reset),
        .load_req     (load_req),
        .bus          (bus),
        .core_reset   (core_reset),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    wr_t        exp_q [$];
    logic [7:0] sum;
    vec_t       vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h required no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({bus.imem_addr, bus.imem_wdata} !== e) begin
                    fails++;
                    $display("FAIL imem_write: got addr %h data %h required addr %h data %h",
                             bus.imem_addr, bus.imem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        if (last) check("core_reset_held", core_reset, 1);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input int a, input logic [31:0] w, input bit last);
        wr_t e;
        e.addr = 8'(a);
        e.data = w;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] b;
            b   = w[8*k +: 8];
            sum = sum + b;
            send_byte(b, last && (k == 3));
        end
        check("we_after_4th_byte", bus.imem_we, 1);
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check("restart_core_reset", core_reset, 1);
        check("restart_load_done", load_done, 0);
    endtask

    task automatic expect_status(input string tag, input bit err);
        check({tag, "_core_reset"}, core_reset, err ? 1 : 0);
        check({tag, "_load_done"}, load_done, err ? 0 : 1);
        check({tag, "_load_error"}, load_error, err ? 1 : 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_we"}, bus.imem_we, 0);
        check({tag, "_imem_addr"}, bus.imem_addr, 0);
        check({tag, "_imem_wdata"}, bus.imem_wdata, 0);
        check({tag, "_core_reset"}, core_reset, 1);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_load_error"}, load_error, 0);
    endtask

    // Simple single-word load from LEN_LO, ending in RUN.
    task automatic load_one(input logic [31:0] w);
        sum = 8'h00;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(0, w, !CHK_ON);
        if (CHK_ON) send_byte(sum, 1);
        expect_status("one", 0);
    endtask

    function automatic logic [31:0] word_of(input int v, input int i);
        logic [7:0] x;
        x = 8'(i);
        if (vecs[v].gen) return {x ^ 8'hA5, x, ~x, x + 8'h3C};
        return vecs[v].w[i];
    endfunction

    task automatic set_vec(input int idx, input logic [15:0] len, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2, input bit gen,
                           input bit bad, input bit err);
        vecs[idx].len       = len;
        vecs[idx].w[0]      = w0;
        vecs[idx].w[1]      = w1;
        vecs[idx].w[2]      = w2;
        vecs[idx].gen       = gen;
        vecs[idx].bad_chk   = bad;
        vecs[idx].exp_error = err;
    endtask

    initial begin
        global_reset = 1'b1;
        load_req     = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        set_vec(0, 16'd2,   32'h00100013, 32'h00200093, 32'h0,        0, 0, 0);
        set_vec(1, 16'd0,   32'h0,        32'h0,        32'h0,        0, 0, 0);
        set_vec(2, 16'h0101, 32'h0,       32'h0,        32'h0,        0, 0, 1);
        set_vec(3, 16'd2,   32'h00100013, 32'h00200093, 32'h0,        0, 1, CHK_ON);
        set_vec(4, 16'd3,   32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 0, 0, 0);
        set_vec(5, 16'd256, 32'h0,        32'h0,        32'h0,        1, 0, 0);
        set_vec(6, 16'd1,   32'hCAFEF00D, 32'h0,        32'h0,        0, 0, 0);

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        global_reset = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            logic [15:0] n;
            bit          big;
            n   = vecs[v].len;
            big = (n > 16'd256);
            if (v != 0) pulse_load_req();
            sum = 8'h00;
            send_byte(n[7:0], 0);
            send_byte(n[15:8], !big && (n == 16'd0) && !CHK_ON);
            for (int i = 0; i < int'(n) && !big; i++) begin
                send_word(i, word_of(v, i), (i == int'(n) - 1) && !CHK_ON);
            end
            if (CHK_ON && !big) send_byte(vecs[v].bad_chk ? 8'h00 : sum, 1);
            expect_status("vec", vecs[v].exp_error);
            if (vecs[v].exp_error) begin
                for (int k = 0; k < 4; k++) send_byte(8'h11 * 8'(k + 1), 0);
                expect_status("vec_sink", 1);
            end
            tick();
            check("pending_writes", exp_q.size(), 0);
            $display("[TB] vector %0d len=%0d load_done=%0b load_error=%0b",
                     v, n, load_done, load_error);
        end

        // Asynchronous reset half-way through the second word discards the partial word.
        pulse_load_req();
        sum = 8'h00;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(0, 32'h11223344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        global_reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        global_reset = 1'b0;
        tick();
        load_one(32'h0BADF00D);
        tick();
        check("abort_pending_writes", exp_q.size(), 0);
        $display("[TB] abort-and-reload load_done=%0b", load_done);

        // Bytes in RUN are ignored; load_req with a byte restarts and drops that byte.
        for (int k = 0; k < 3; k++) send_byte(8'hAA, 0);
        expect_status("run_ignore", 0);
        load_req     = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h05;
        tick();
        load_req     = 1'b0;
        bus.rx_valid = 1'b0;
        check("req_rx_core_reset", core_reset, 1);
        check("req_rx_load_done", load_done, 0);
        load_one(32'h76543210);
        tick();
        check("final_pending_writes", exp_q.size(), 0);
        $display("[TB] run-ignore and restart load_done=%0b", load_done);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
